// File: rtl/w_mem_reader_if.sv
// Handshake bundle between a weight memory, its read sequencer and the neuron MAC.
// W_MEM_READER_BIAS_EN adds the bias_in word carried as a trailing beat.
interface w_mem_reader_if #(
  parameter int addressWidth = 4,
  parameter int dataWidth    = 16
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    mem_ren;
  logic [addressWidth-1:0] mem_radd;
  logic [dataWidth-1:0]    mem_wout;
  logic                    w_valid;
  logic                    w_ready;
  logic [dataWidth-1:0]    w_data;
  logic [addressWidth-1:0] w_idx;
  logic                    w_last;
`ifdef W_MEM_READER_BIAS_EN
  logic [dataWidth-1:0]    bias_in;
`endif

  modport master (
`ifdef W_MEM_READER_BIAS_EN
    input  bias_in,
`endif
    input  start, mem_wout, w_ready,
    output busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last
  );

  modport slave (
`ifdef W_MEM_READER_BIAS_EN
    output bias_in,
`endif
    output start, mem_wout, w_ready,
    input  busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/w_mem_reader.sv
// Weight-memory read sequencer: issues reads 0..numWeight-1 under a 2-entry credit
// and streams the words out over valid/ready. W_MEM_READER_BIAS_EN appends a bias beat.
module w_mem_reader #(
  parameter int numWeight    = 10,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic           clk,
  input  logic           rst,
  w_mem_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [dataWidth-1:0]    data;
    logic [addressWidth-1:0] idx;
    logic                    last;
  } beat_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

  state_t                  state, state_nxt;
  logic [addressWidth-1:0] cnt, radd_q;
  logic                    infl, infl_bias, bias_ph;
  logic                    issue, ren, credit, last_issue, push, pop;
  beat_t                   fifo [2];
  beat_t                   push_beat, head;
  logic                    rd_ptr, wr_ptr;
  logic [1:0]              occ;

  assign pop  = (occ != 2'd0) && bus.w_ready;
  assign push = infl;
  // Entries committed (buffered + in flight) after this cycle's pop must leave room.
  assign credit = ({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, pop});

`ifdef W_MEM_READER_BIAS_EN
  assign last_issue = bias_ph;
`else
  assign bias_ph    = 1'b0;
  assign last_issue = (cnt == LAST_ADDR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    ren       = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: if (credit) begin
        issue = 1'b1;
        ren   = !bias_ph;
        if (last_issue) state_nxt = DRAIN;
      end
      // Leave once the final beat is popped this cycle and nothing else can land.
      DRAIN: if (!infl && (occ == 2'd0 || (occ == 2'd1 && pop))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      radd_q    <= '0;
      infl      <= 1'b0;
      infl_bias <= 1'b0;
`ifdef W_MEM_READER_BIAS_EN
      bias_ph   <= 1'b0;
`endif
    end else begin
      infl      <= issue;
      infl_bias <= issue && bias_ph;
      if (state == IDLE && bus.start) begin
        cnt     <= '0;
        radd_q  <= '0;
`ifdef W_MEM_READER_BIAS_EN
        bias_ph <= 1'b0;
`endif
      end else if (issue && !bias_ph) begin
        radd_q <= cnt;
        if (cnt != LAST_ADDR) cnt <= cnt + addressWidth'(1);
`ifdef W_MEM_READER_BIAS_EN
        else bias_ph <= 1'b1;
`endif
      end
`ifdef W_MEM_READER_BIAS_EN
      else if (issue) bias_ph <= 1'b0;
`endif
    end
  end

  always_comb begin
    push_beat.data = bus.mem_wout;
    push_beat.idx  = radd_q;
`ifdef W_MEM_READER_BIAS_EN
    push_beat.last = 1'b0;
    if (infl_bias) begin
      push_beat.data = bus.bias_in;
      push_beat.idx  = '0;
      push_beat.last = 1'b1;
    end
`else
    push_beat.last = (radd_q == LAST_ADDR) && !infl_bias;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= push_beat;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head         = fifo[rd_ptr];
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.mem_ren  = ren;
  // Between issues the address holds the last one sent.
  assign bus.mem_radd = ren ? cnt : radd_q;
  assign bus.w_valid  = (occ != 2'd0);
  assign bus.w_data   = head.data;
  assign bus.w_idx    = head.idx;
  assign bus.w_last   = head.last;
endmodule
